seg7_scan_capture: RTL and testbench

Parametrised capture stage that turns a dynamically scanned seven-segment bus (one-hot `digit` strobe plus shared `hgfedcba` segments) into per-digit static registers for boards with static displays or serial LED drivers. It extends plain per-digit latching with four additions:

- a glitch filter that requires a stable scan slot before committing;
- per-digit staleness timeout with blanking;
- one-hot violation detection and counting;
- a frame-complete pulse.

It sits between the lab's display scanner and the static/serial display driver.

---
 rtl/seg7_scan_capture.sv | 81 ++++++++
 tb/tb_seg7_scan_capture.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: filters a scanned 7-seg bus into per-digit static registers with timeout, frame pulse and one-hot error tracking.
module seg7_scan_capture #(
  parameter int W_DIGIT        = 8,
  parameter int W_SEG          = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int R_INIT         = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_SEG-1:0]   hgfedcba,
  input  logic [W_DIGIT-1:0] digit,
  output logic [W_SEG-1:0]   hex [W_DIGIT],
  output logic [W_DIGIT-1:0] valid,
  output logic               frame_pulse,
  output logic               err_onehot,
  output logic [15:0]        err_count
);
  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [63:0] GLYPHS = 64'h077d6d664f5b063f;
  logic [W_DIGIT-1:0] dig_q, dig_p, seen, seen_all;
  logic [W_SEG-1:0]   seg_q, seg_p;
  logic [W_SEG-1:0]   init_hex [W_DIGIT];
  logic [TW-1:0]      timer [W_DIGIT];
  logic [RW-1:0]      run, run_nxt;
  logic               good, same, commit;
  for (genvar g = 0; g < W_DIGIT; g++) begin : g_init
    assign init_hex[g] = R_INIT != 0 ? W_SEG'(GLYPHS[8*(g%8) +: 8]) : '0;
  end
  always_comb begin
    good       = dig_q != '0 && (dig_q & (dig_q - W_DIGIT'(1))) == '0;
    err_onehot = dig_q != '0 && !good;
    same       = {dig_q, seg_q} == {dig_p, seg_p};
    run_nxt    = !good ? '0 : !same ? RW'(1) : run == RW'(STABLE_CYCLES) ? run : run + 1'b1;
    // a differing sample starts a new run, so it may commit again when S is 1
    commit     = good && run_nxt == RW'(STABLE_CYCLES) && (!same || run != RW'(STABLE_CYCLES));
    seen_all   = seen | (commit ? dig_q : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q       <= '0;
      dig_p       <= '0;
      seg_q       <= '0;
      seg_p       <= '0;
      run         <= '0;
      seen        <= '0;
      valid       <= '0;
      frame_pulse <= 1'b0;
      err_count   <= '0;
      for (int i = 0; i < W_DIGIT; i++) begin
        hex[i]   <= init_hex[i];
        timer[i] <= '0;
      end
    end else begin
      dig_q       <= digit;
      seg_q       <= hgfedcba;
      dig_p       <= dig_q;
      seg_p       <= seg_q;
      run         <= run_nxt;
      err_count   <= err_count + 16'(err_onehot && err_count != 16'hFFFF);
      frame_pulse <= commit && &seen_all;
      seen        <= commit && &seen_all ? '0 : seen_all;
      for (int i = 0; i < W_DIGIT; i++) begin
        if (commit && dig_q[i]) begin
          hex[i]   <= seg_q;
          valid[i] <= 1'b1;
          timer[i] <= '0;
        end else if (valid[i] && TIMEOUT_CYCLES != 0) begin
          if (timer[i] == TW'(TIMEOUT_CYCLES - 1)) begin
            hex[i]   <= '0;
            valid[i] <= 1'b0;
            timer[i] <= '0;
          end else begin
            timer[i] <= timer[i] + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: randomized and directed stimulus checked against a timestamp-based reference model.
module tb_seg7_scan_capture;
  localparam int S = 4;
  localparam int T = 100;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] hgfedcba = '0;
  logic [7:0] digit = '0;
  logic [7:0] hex [8];
  logic [7:0] valid;
  logic       frame_pulse, err_onehot;
  logic [15:0] err_count;
  seg7_scan_capture #(.W_DIGIT(8), .W_SEG(8), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .R_INIT(1)) dut (
    .clk(clk), .rst(rst), .hgfedcba(hgfedcba), .digit(digit), .hex(hex), .valid(valid),
    .frame_pulse(frame_pulse), .err_onehot(err_onehot), .err_count(err_count)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] glyph [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
  logic [7:0] m_seg [8];
  int         m_edge [8];
  logic [7:0] m_done, m_seen, prev_d, prev_s, pend_seg;
  int         m_len, m_err, k, pend_idx;
  logic       pend, pend_bad, exp_eh, exp_pulse;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_done = '0; m_seen = '0; prev_d = '0; prev_s = '0; m_len = 0; m_err = 0;
    pend = 0; pend_bad = 0; exp_eh = 0; exp_pulse = 0;
  endtask
  task automatic check_all();
    logic [63:0] eh, oh;
    logic [7:0] ev;
    for (int i = 0; i < 8; i++) begin
      ev[i] = m_done[i] && (k - m_edge[i] < T);
      eh[8*i +: 8] = ev[i] ? m_seg[i] : (m_done[i] ? 8'h00 : glyph[i]);
      oh[8*i +: 8] = hex[i];
    end
    check("hex", oh, eh);
    check("valid", 64'(valid), 64'(ev));
    check("frame_pulse", 64'(frame_pulse), 64'(exp_pulse));
    check("err_onehot", 64'(err_onehot), 64'(exp_eh));
    check("err_count", 64'(err_count), 64'(m_err));
  endtask
  task automatic step(input logic [7:0] d, input logic [7:0] s);
    bit good, bad;
    digit = d;
    hgfedcba = s;
    @(posedge clk);
    #1;
    k++;
    if (rst) model_reset();
    else begin
      exp_pulse = 0;
      if (pend) begin
        m_seg[pend_idx] = pend_seg;
        m_edge[pend_idx] = k;
        m_done[pend_idx] = 1;
        m_seen[pend_idx] = 1;
        if (m_seen == 8'hFF) begin
          exp_pulse = 1;
          m_seen = '0;
        end
      end
      if (pend_bad && m_err < 65535) m_err++;
      good = $countones(d) == 1;
      bad = d != 0 && !good;
      m_len = good ? ((d == prev_d && s == prev_s) ? m_len + 1 : 1) : 0;
      pend = m_len == S;
      pend_idx = $clog2(d);
      pend_seg = s;
      pend_bad = bad;
      exp_eh = bad;
      prev_d = d;
      prev_s = s;
    end
    check_all();
  endtask
  task automatic hold(input logic [7:0] d, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(d, s);
  endtask
  task automatic scan(input int skip);
    for (int i = 0; i < 8; i++)
      if (i != skip) hold(8'(1 << i), glyph[7 - i], S);
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    check_all();
    hold(8'h00, 8'h00, 2);
    rst = 0;
  endtask
  initial begin
    k = 0;
    model_reset();
    hold(8'h00, 8'h00, 2);
    rst = 0;
    hold(8'h00, 8'h00, 1);
    hold(8'h04, 8'h5B, 4);
    hold(8'h00, 8'h00, 2);
    hold(8'h01, 8'h06, 3);
    hold(8'h00, 8'h00, 2);
    hold(8'h01, 8'h06, 4);
    hold(8'h00, 8'h00, 1);
    hold(8'h01, 8'h3F, 20);
    hold(8'h01, 8'h4F, 2);
    hold(8'h00, 8'h00, 2);
    scan(-1);
    scan(-1);
    scan(5);
    hold(8'h00, 8'h00, 3);
    hold(8'h08, 8'h4F, 4);
    hold(8'h00, 8'h00, 105);
    hold(8'h08, 8'h4F, 4);
    hold(8'h00, 8'h00, 94);
    hold(8'h08, 8'h66, 4);
    hold(8'h00, 8'h00, 10);
    hold(8'h06, 8'h5B, 5);
    hold(8'h00, 8'h00, 3);
    hold(8'hC0, 8'h11, 2);
    hold(8'h00, 8'h00, 2);
    hold(8'h02, 8'h5B, 2);
    do_reset();
    scan(6);
    hold(8'h10, 8'h66, 2);
    do_reset();
    hold(8'h01, 8'h3F, 2);
    scan(-1);
    hold(8'h00, 8'h00, 2);
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 11);
      logic [7:0] s = glyph[$urandom_range(0, 7)];
      int len = $urandom_range(1, 6);
      if (r < 6) hold(8'(1 << $urandom_range(0, 7)), s, len);
      else if (r == 6) hold(8'h00, 8'h00, len);
      else if (r == 7) hold(8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)), s, len);
      else if (r == 8) scan(-1);
      else if (r == 9) hold(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), len);
      else if (r == 10 && $urandom_range(0, 9) == 0) do_reset();
      else hold(8'h20, s, len);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
